// File: rtl/block_transfer_unit.sv
// ARM LDM/STM engine: one word access per cycle, lowest register at lowest address.
// Latency: N+1 cycles of busy after start; done pulses in the last one. No backpressure, start ignored while busy.
module block_transfer_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        up,
  input  logic [31:0] base_addr,
  input  logic [15:0] reg_list,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_result,
  output logic [3:0]  store_reg_idx,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic        wb_en,
  output logic [3:0]  wb_reg,
  output logic [31:0] wb_value,
  output logic        busy,
  output logic        done,
  output logic [31:0] final_addr
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] list_q, list_d;
  logic [31:0] addr_q, addr_d;
  logic        is_load_q, is_load_d;
  logic [31:0] final_addr_q, final_addr_d;

  logic [4:0]  count;
  logic [3:0]  idx;
  logic [15:0] list_rest;
  logic [31:0] base_aligned;
  logic [31:0] span;

  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) begin
      count = count + {4'b0, reg_list[i]};
    end
  end

  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) idx = 4'(i);
    end
  end

  // Clearing the lowest set bit drives the ascending register order.
  assign list_rest    = list_q & (list_q - 16'd1);
  assign base_aligned = {base_addr[31:2], 2'b00};
  assign span         = {25'b0, count, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      list_q       <= '0;
      addr_q       <= '0;
      is_load_q    <= 1'b0;
      final_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      list_q       <= list_d;
      addr_q       <= addr_d;
      is_load_q    <= is_load_d;
      final_addr_q <= final_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    list_d       = list_q;
    addr_d       = addr_q;
    is_load_d    = is_load_q;
    final_addr_d = final_addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          is_load_d = is_load;
          list_d    = reg_list;
          if (up) begin
            addr_d       = base_aligned;
            final_addr_d = base_aligned + span;
          end else begin
            addr_d       = base_aligned - span;
            final_addr_d = base_aligned - span;
          end
          state_d = (count == 5'd0) ? DONE : XFER;
        end
      end
      XFER: begin
        list_d = list_rest;
        addr_d = addr_q + 32'd4;
        if (list_rest == 16'd0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Enables drop with rst so the access in the reset cycle never lands.
  always_comb begin
    store_reg_idx = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_data      = '0;
    wb_en         = 1'b0;
    wb_reg        = '0;
    wb_value      = '0;
    busy          = (state_q != IDLE);
    done          = (state_q == DONE);
    final_addr    = final_addr_q;
    if (state_q == XFER && !rst) begin
      mem_address = addr_q;
      if (is_load_q) begin
        mem_read = 1'b1;
        wb_en    = 1'b1;
        wb_reg   = idx;
        wb_value = mem_result;
      end else begin
        mem_write     = 1'b1;
        store_reg_idx = idx;
        mem_data      = store_data;
      end
    end
  end

endmodule
